// File: rtl/trap_seq_pkg.sv
// Shared types and constants for the trapezoidal-filter sequencer.
// Holds the FSM state enum, data/index widths and the peak reset value.
package trap_seq_pkg;

    localparam int W     = 16;
    localparam int IDX_W = 8;

    localparam logic signed [W-1:0] PEAK_INIT = 16'sh8000;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARMED,
        ACQUIRE,
        RESULT
    } state_t;

endpackage

// File: rtl/trap_filter_seq_thr_cross_det.sv
// Rising threshold-crossing detector for the ADC sample stream.
// Ports: i_clk, i_rst_n (async, active-low), i_in (sample), i_threshold,
//        o_cross (combinational pulse: previous <= thr and current > thr, signed).
module thr_cross_det
    import trap_seq_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_in,
    input  logic [W-1:0] i_threshold,
    output logic         o_cross
);

    logic [W-1:0] r_in_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_prev <= '0;
        end else begin
            r_in_prev <= i_in;
        end
    end

    assign o_cross = ($signed(r_in_prev) <= $signed(i_threshold)) &&
                     ($signed(i_in) > $signed(i_threshold));

endmodule

// File: rtl/trap_filter_seq.sv
// Event sequencer for the 16-bit trapezoidal shaping filter: arms on a
// threshold crossing, clears/releases the filter, tracks the peak of
// ACQ_LEN output samples and hands {peak, peak_idx} out on valid/ready.
// Ports: clk, reset (async active-low), enable, in, threshold,
//        filt_rst/filt_in (to filter), filt_out (from filter),
//        peak, peak_idx, res_valid, res_ready, busy, evt_cnt, pileup.
// Build option: define PILEUP_REJECT_EN to discard windows that see a
// second crossing after HOLDOFF samples (pileup pulses, back to CLEAR).
module trap_filter_seq
    import trap_seq_pkg::*;
#(
    parameter int ACQ_LEN = 24,
    parameter int CLR_LEN = 2,
    parameter int HOLDOFF = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [W-1:0]     in,
    input  logic [W-1:0]     threshold,
    output logic             filt_rst,
    output logic [W-1:0]     filt_in,
    input  logic [W-1:0]     filt_out,
    output logic [W-1:0]     peak,
    output logic [IDX_W-1:0] peak_idx,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [15:0]      evt_cnt,
    output logic             pileup
);

    localparam int CLR_W = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_LEN - 1);
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(ACQ_LEN - 1);
    localparam logic [IDX_W-1:0] HOLD_CNT = IDX_W'(HOLDOFF);

`ifdef PILEUP_REJECT_EN
    localparam bit PILE_EN = 1'b1;
`else
    localparam bit PILE_EN = 1'b0;
`endif

    state_t           r_state;
    logic [CLR_W-1:0] r_clr_cnt;
    logic [IDX_W-1:0] r_cnt;
    logic             r_first;
    logic             r_filt_rst;
    logic [W-1:0]     r_filt_in;
    logic [W-1:0]     r_peak;
    logic [IDX_W-1:0] r_peak_idx;
    logic             r_res_valid;
    logic             r_busy;
    logic [15:0]      r_evt_cnt;
    logic             r_pileup;

    logic             w_cross;
    logic             w_pile_hit;

    thr_cross_det u_cross (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_in        (in),
        .i_threshold (threshold),
        .o_cross     (w_cross)
    );

    assign w_pile_hit = PILE_EN && w_cross && (r_cnt >= HOLD_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_clr_cnt   <= '0;
            r_cnt       <= '0;
            r_first     <= 1'b0;
            r_filt_rst  <= 1'b1;
            r_filt_in   <= '0;
            r_peak      <= PEAK_INIT;
            r_peak_idx  <= '0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_evt_cnt   <= '0;
            r_pileup    <= 1'b0;
        end else begin
            r_filt_in <= in;
            r_pileup  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_filt_rst <= 1'b1;
                    r_busy     <= 1'b0;
                    if (enable) begin
                        r_state   <= CLEAR;
                        r_busy    <= 1'b1;
                        r_clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_clr_cnt == CLR_LAST) begin
                        r_state <= ARMED;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                ARMED: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_cross) begin
                        // Releasing now makes the trigger sample (registered
                        // into filt_in this edge) the filter's first input.
                        r_state    <= ACQUIRE;
                        r_filt_rst <= 1'b0;
                        r_cnt      <= '0;
                        r_first    <= 1'b1;
                        r_peak     <= PEAK_INIT;
                        r_peak_idx <= '0;
                    end
                end
                ACQUIRE: begin
                    if (!enable) begin
                        r_state    <= IDLE;
                        r_filt_rst <= 1'b1;
                        r_busy     <= 1'b0;
                    end else if (w_pile_hit) begin
                        r_state    <= CLEAR;
                        r_filt_rst <= 1'b1;
                        r_clr_cnt  <= '0;
                        r_pileup   <= 1'b1;
                    end else if (r_first) begin
                        // Filter output lags its input by one clock.
                        r_first <= 1'b0;
                    end else begin
                        if ($signed(filt_out) > $signed(r_peak)) begin
                            r_peak     <= filt_out;
                            r_peak_idx <= r_cnt;
                        end
                        if (r_cnt == CNT_LAST) begin
                            r_state     <= RESULT;
                            r_filt_rst  <= 1'b1;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_evt_cnt   <= r_evt_cnt + 16'd1;
                        if (enable) begin
                            r_state   <= CLEAR;
                            r_clr_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_filt_rst <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign filt_rst  = r_filt_rst;
    assign filt_in   = r_filt_in;
    assign peak      = r_peak;
    assign peak_idx  = r_peak_idx;
    assign res_valid = r_res_valid;
    assign busy      = r_busy;
    assign evt_cnt   = r_evt_cnt;
    assign pileup    = r_pileup;

endmodule

// File: tb/tb_trap_filter_seq.sv
// Bench for trap_filter_seq with a 4/6-tap trapezoidal filter in the loop.
// Step of amplitude A gives outputs A*{1,2,3,4,4,4,3,2,1,0,...}.
module tb_trap_filter_seq;

    localparam int ACQ = 24;

`ifdef PILEUP_REJECT_EN
    localparam bit PILE = 1'b1;
`else
    localparam bit PILE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        res_ready;
    logic [15:0] in_s;
    logic [15:0] threshold;
    logic [15:0] filt_in;
    logic [15:0] filt_out = '0;
    logic [15:0] peak;
    logic [7:0]  peak_idx;
    logic        filt_rst;
    logic        res_valid;
    logic        busy;
    logic [15:0] evt_cnt;
    logic        pileup;

    int          errs   = 0;
    int          checks = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    trap_filter_seq #(.ACQ_LEN(ACQ), .CLR_LEN(2), .HOLDOFF(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in        (in_s),
        .threshold (threshold),
        .filt_rst  (filt_rst),
        .filt_in   (filt_in),
        .filt_out  (filt_out),
        .peak      (peak),
        .peak_idx  (peak_idx),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .evt_cnt   (evt_cnt),
        .pileup    (pileup)
    );

    // Trapezoid: d = x - x[n-4] - x[n-6] + x[n-10], accumulated.
    logic [15:0] f_h [10];
    always @(posedge clk) begin
        if (filt_rst) begin
            for (int i = 0; i < 10; i++) f_h[i] <= '0;
            filt_out <= '0;
        end else begin
            f_h[0] <= filt_in;
            for (int i = 1; i < 10; i++) f_h[i] <= f_h[i-1];
            filt_out <= filt_out + filt_in - f_h[3] - f_h[5] + f_h[9];
        end
    end

    typedef struct {
        logic [15:0] base;
        logic [15:0] amp;
        logic [15:0] thr;
        logic [15:0] exp_peak;
        logic [7:0]  exp_idx;
        int          hold;
        bit          preload;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        threshold = v.thr;
        in_s      = v.base;
        repeat (5) tick();
        if (v.preload) begin
            force dut.r_evt_cnt = 16'hFFFF;
            #1;
            release dut.r_evt_cnt;
            exp_cnt = 16'hFFFF;
        end
        in_s = v.amp;
        tick();
        chk("trig_release", 32'(filt_rst), 0);
        repeat (ACQ) tick();
        chk("valid_early", 32'(res_valid), 0);
        tick();
        chk("valid_latency", 32'(res_valid), 1);
        chk("peak", 32'(peak), 32'(v.exp_peak));
        chk("peak_idx", 32'(peak_idx), 32'(v.exp_idx));
        if (v.hold > 0) begin
            repeat (v.hold) tick();
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_peak", 32'(peak), 32'(v.exp_peak));
            chk("hold_idx", 32'(peak_idx), 32'(v.exp_idx));
            chk("hold_cnt", 32'(evt_cnt), 32'(exp_cnt));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
        chk("accept_valid", 32'(res_valid), 0);
        chk("evt_cnt", 32'(evt_cnt), 32'(exp_cnt));
        chk("reclear_busy", 32'(busy), 1);
        chk("reclear_rst", 32'(filt_rst), 1);
    endtask

    task automatic run_dip(input int dip, input bit pile,
                           input logic [15:0] ep, input logic [7:0] ei);
        int e;
        int seen;
        threshold = 16'd100;
        in_s      = 16'd0;
        repeat (5) tick();
        in_s = 16'd500;
        tick();
        e = 1;
        while (e < dip + 1) begin
            tick();
            e++;
        end
        in_s = 16'd0;
        tick();
        e++;
        in_s = 16'd500;
        if (pile) begin
            tick();
            chk("pile_pulse", 32'(pileup), 1);
            chk("pile_novalid", 32'(res_valid), 0);
            chk("pile_clear", 32'(filt_rst), 1);
            tick();
            chk("pile_1cyc", 32'(pileup), 0);
            seen = 0;
            repeat (ACQ + 4) begin
                tick();
                if (res_valid) seen++;
            end
            chk("pile_noresult", 32'(seen), 0);
            chk("pile_cnt", 32'(evt_cnt), 32'(exp_cnt));
        end else begin
            seen = 0;
            while (e < ACQ + 2) begin
                tick();
                e++;
                if (pileup) seen++;
            end
            chk("dip_nopile", 32'(seen), 0);
            chk("dip_valid", 32'(res_valid), 1);
            chk("dip_peak", 32'(peak), 32'(ep));
            chk("dip_idx", 32'(peak_idx), 32'(ei));
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            exp_cnt   = exp_cnt + 16'd1;
            chk("dip_cnt", 32'(evt_cnt), 32'(exp_cnt));
        end
    endtask

    initial begin
        vt[0] = '{16'd0,      16'd500,   16'd100,   16'd2000,  8'd3, 10, 1'b0};
        vt[1] = '{16'd100,    16'd101,   16'd100,   16'd404,   8'd3, 0,  1'b0};
        vt[2] = '{16'd0,      16'd1000,  16'd999,   16'd4000,  8'd3, 0,  1'b0};
        vt[3] = '{16'd0,      16'd8191,  16'd0,     16'h7FFC,  8'd3, 0,  1'b0};
        vt[4] = '{-16'sd200,  -16'sd10,  -16'sd50,  16'd0,     8'd9, 0,  1'b1};
        vt[5] = '{-16'sd300,  16'd20,    -16'sd1,   16'd80,    8'd3, 0,  1'b0};

        reset     = 1'b0;
        enable    = 1'b0;
        in_s      = 16'd0;
        threshold = 16'd0;
        res_ready = 1'b0;
        exp_cnt   = 16'd0;
        repeat (2) tick();
        chk("rst_filt_rst", 32'(filt_rst), 1);
        chk("rst_filt_in", 32'(filt_in), 0);
        chk("rst_peak", 32'(peak), 32'h8000);
        chk("rst_idx", 32'(peak_idx), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_evt", 32'(evt_cnt), 0);
        chk("rst_pile", 32'(pileup), 0);
        in_s = 16'd77;
        tick();
        chk("rst_hold_in", 32'(filt_in), 0);
        reset = 1'b1;
        tick();
        chk("filt_in_copy", 32'(filt_in), 77);
        chk("idle_busy", 32'(busy), 0);

        enable = 1'b1;
        in_s   = 16'd0;
        tick();
        chk("clear_busy", 32'(busy), 1);
        chk("clear_rst", 32'(filt_rst), 1);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Sample equal to threshold is not a crossing.
        threshold = 16'd100;
        in_s      = 16'd0;
        repeat (5) tick();
        in_s = 16'd100;
        repeat (4) tick();
        chk("eq_no_trig", 32'(filt_rst), 1);

        run_dip(2, 1'b0, 16'd1500, 8'd2);
        run_dip(8, PILE, 16'd2000, 8'd3);

        // Abort at cnt=5.
        threshold = 16'd100;
        in_s      = 16'd0;
        repeat (5) tick();
        in_s = 16'd500;
        repeat (7) tick();
        enable = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rst", 32'(filt_rst), 1);
        begin
            int seen;
            seen = 0;
            repeat (ACQ + 4) begin
                tick();
                if (res_valid) seen++;
            end
            chk("abort_noresult", 32'(seen), 0);
        end
        chk("abort_cnt", 32'(evt_cnt), 32'(exp_cnt));
        enable = 1'b1;
        in_s   = 16'd0;
        tick();
        chk("rearm_busy", 32'(busy), 1);

        // Async reset mid-ACQUIRE.
        repeat (5) tick();
        in_s = 16'd500;
        repeat (6) tick();
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(res_valid), 0);
        chk("arst_rst", 32'(filt_rst), 1);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_evt", 32'(evt_cnt), 0);
        chk("arst_peak", 32'(peak), 32'h8000);
        exp_cnt = 16'd0;
        tick();
        enable = 1'b0;
        reset  = 1'b1;
        repeat (3) tick();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_frst", 32'(filt_rst), 1);
        enable = 1'b1;
        run_vec(vt[1]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
